load_store_unit: RTL and testbench

Multi-cycle data-memory front end for the RV SiMPLE single-cycle core. It sits between the datapath's data-memory port and an external req/ack data bus. It takes the datapath's address and store data together with the decoded load/store controls, and runs one bus transaction per access. It returns aligned, sign- or zero-extended load data to the datapath and stalls the core until the access completes.

---
 rtl/rv_constants.sv | 28 ++
 rtl/lsu_lane_formatter.sv | 50 +++++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv_constants.sv
// Shared load/store constants: funct3 size/sign codes and the LSU state encoding.
package rv_constants;

  localparam int FUNCT3_W = 3;

  localparam logic [FUNCT3_W-1:0] LSU_B  = 3'b000;
  localparam logic [FUNCT3_W-1:0] LSU_H  = 3'b001;
  localparam logic [FUNCT3_W-1:0] LSU_W  = 3'b010;
  localparam logic [FUNCT3_W-1:0] LSU_BU = 3'b100;
  localparam logic [FUNCT3_W-1:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  // Halfwords need an even address, words a 4-byte aligned one.
  function automatic logic is_misaligned(input logic [FUNCT3_W-1:0] f3,
                                         input logic [1:0] off);
    case (f3[1:0])
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_formatter.sv
// Combinational byte-lane steering: byte enables and replicated store data
// toward the bus, shifted and sign/zero-extended load data back from it.
module lsu_lane_formatter
  import rv_constants::*;
(
  input  logic [FUNCT3_W-1:0] funct3_i,
  input  logic [1:0]          offset_i,
  input  logic [31:0]         write_data_i,
  input  logic [31:0]         bus_rdata_i,
  output logic [3:0]          bus_be_o,
  output logic [31:0]         bus_wdata_o,
  output logic [31:0]         load_data_o
);

  logic [1:0]  lane;
  logic [31:0] shifted;

  always_comb begin
    lane        = 2'b00;
    bus_be_o    = 4'b1111;
    bus_wdata_o = write_data_i;
    case (funct3_i)
      LSU_B, LSU_BU: begin
        lane        = offset_i;
        bus_be_o    = 4'b0001 << lane;
        bus_wdata_o = {4{write_data_i[7:0]}};
      end
      LSU_H, LSU_HU: begin
        // address[0] is dropped: halfwords always sit on lane 0 or 2
        lane        = {offset_i[1], 1'b0};
        bus_be_o    = 4'b0011 << lane;
        bus_wdata_o = {2{write_data_i[15:0]}};
      end
      default: ;
    endcase

    shifted     = bus_rdata_i >> {lane, 3'b000};
    load_data_o = shifted;
    case (funct3_i)
      LSU_B, LSU_BU:
        load_data_o = funct3_i[2] ? {24'h0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      LSU_H, LSU_HU:
        load_data_o = funct3_i[2] ? {16'h0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle data-memory front end: one req/ack bus transaction per access,
// stalling the core until done. Optional LSU_MISALIGN_TRAP_EN traps misaligned H/W.
module load_store_unit
  import rv_constants::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                mem_read,
  input  logic                mem_write,
  input  logic [FUNCT3_W-1:0] funct3,
  input  logic [31:0]         address,
  input  logic [31:0]         write_data,
  output logic [31:0]         read_data,
  output logic                stall,
  output logic                bus_error,
  output logic                bus_req,
  output logic                bus_we,
  output logic [31:0]         bus_addr,
  output logic [3:0]          bus_be,
  output logic [31:0]         bus_wdata,
  input  logic                bus_ack,
  input  logic [31:0]         bus_rdata
);

  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [FUNCT3_W-1:0] f3_q, f3_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                we_q, we_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic [3:0]  be_fmt;
  logic [31:0] wdata_fmt;
  logic [31:0] load_fmt;
  logic        in_req;

  lsu_lane_formatter u_fmt (
    .funct3_i     (f3_q),
    .offset_i     (addr_q[1:0]),
    .write_data_i (wdata_q),
    .bus_rdata_i  (bus_rdata),
    .bus_be_o     (be_fmt),
    .bus_wdata_o  (wdata_fmt),
    .load_data_o  (load_fmt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    wdata_d = wdata_q;
    we_d    = we_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_read || mem_write) begin
          addr_d  = address;
          f3_d    = funct3;
          wdata_d = write_data;
          we_d    = mem_write;
          cnt_d   = '0;
          state_d = REQ;
`ifdef LSU_MISALIGN_TRAP_EN
          if (is_misaligned(funct3, address[1:0])) begin
            state_d = DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end
`endif
        end
      end
      REQ: begin
        if (bus_ack) begin
          if (!we_q) rdata_d = load_fmt;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus fields are forced to zero outside REQ so an idle bus is quiet.
  assign in_req    = (state_q == REQ);
  assign stall     = ((state_q == IDLE) && (mem_read || mem_write)) || in_req;
  assign bus_req   = in_req;
  assign bus_we    = in_req && we_q;
  assign bus_addr  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_be    = in_req ? be_fmt : 4'h0;
  assign bus_wdata = in_req ? wdata_fmt : 32'h0;
  assign read_data = rdata_q;
  assign bus_error = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with TIMEOUT_CYCLES=4; expected values hand-computed.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] address = 32'h0;
  logic [31:0] write_data = 32'h0;
  logic [31:0] read_data;
  logic        stall;
  logic        bus_error;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .funct3     (funct3),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .stall      (stall),
    .bus_error  (bus_error),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_be     (bus_be),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
    mem_read   = rd;
    mem_write  = wr;
    funct3     = f3;
    address    = addr;
    write_data = wd;
    #1;
  endtask

  task automatic clear_req();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    bus_ack   = 1'b0;
  endtask

  // Single load acked on the first REQ cycle; read_data checked in DONE.
  task automatic load_once(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [31:0] exp);
    start(1'b1, 1'b0, f3, addr, 32'h0);
    tick();
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    tick();
    chk({tag, "_data"}, read_data, exp);
    $display("load %s addr=0x%08h read_data=0x%08h", tag, addr, read_data);
    clear_req();
    tick();
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_bus_error", {31'h0, bus_error}, 32'h0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_bus_fields", {bus_addr[27:0], bus_be}, 32'h0);
    chk("rst_bus_wdata_we", bus_wdata | {31'h0, bus_we}, 32'h0);
    reset = 1'b1;
    tick();

    // LB 0x103: stall high in N and N+1, low in DONE
    start(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0);
    chk("lb_stall_n", {31'h0, stall}, 32'h1);
    chk("lb_req_n", {31'h0, bus_req}, 32'h0);
    tick();
    chk("lb_req_n1", {31'h0, bus_req}, 32'h1);
    chk("lb_stall_n1", {31'h0, stall}, 32'h1);
    chk("lb_addr", bus_addr, 32'h0000_0100);
    chk("lb_be", {28'h0, bus_be}, 32'h8);
    chk("lb_we", {31'h0, bus_we}, 32'h0);
    bus_ack   = 1'b1;
    bus_rdata = 32'h80FF_1234;
    tick();
    chk("lb_stall_done", {31'h0, stall}, 32'h0);
    chk("lb_req_done", {31'h0, bus_req}, 32'h0);
    chk("lb_data", read_data, 32'hFFFF_FF80);
    chk("lb_err", {31'h0, bus_error}, 32'h0);
    $display("load LB addr=0x00000103 read_data=0x%08h", read_data);
    clear_req();
    tick();
    chk("lb_idle_stall", {31'h0, stall}, 32'h0);

    load_once("LBU", 3'b100, 32'h0000_0103, 32'h80FF_1234, 32'h0000_0080);
    load_once("LB2", 3'b000, 32'h0000_0102, 32'h80FF_1234, 32'hFFFF_FFFF);
    load_once("LHU", 3'b101, 32'h0000_0102, 32'h80FF_1234, 32'h0000_80FF);
    load_once("LH", 3'b001, 32'h0000_0100, 32'h80FF_1234, 32'h0000_1234);

    // SB 0x101, ack on the second REQ cycle; fields stable throughout
    start(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB);
    tick();
    chk("sb_we", {31'h0, bus_we}, 32'h1);
    chk("sb_addr", bus_addr, 32'h0000_0100);
    chk("sb_be", {28'h0, bus_be}, 32'h2);
    chk("sb_wdata", bus_wdata, 32'hABAB_ABAB);
    tick();
    chk("sb_req_hold", {31'h0, bus_req}, 32'h1);
    chk("sb_we_hold", {31'h0, bus_we}, 32'h1);
    chk("sb_wdata_hold", bus_wdata, 32'hABAB_ABAB);
    bus_ack = 1'b1;
    tick();
    chk("sb_req_done", {31'h0, bus_req}, 32'h0);
    chk("sb_rd_kept", read_data, 32'h0000_1234);
    $display("store SB addr=0x00000101 done stall=%0b", stall);
    clear_req();
    tick();

    // SH 0x102 with both controls high -> treated as a write
    start(1'b1, 1'b1, 3'b001, 32'h0000_0102, 32'h1234_CAFE);
    tick();
    chk("sh_we", {31'h0, bus_we}, 32'h1);
    chk("sh_be", {28'h0, bus_be}, 32'hC);
    chk("sh_wdata", bus_wdata, 32'hCAFE_CAFE);
    bus_ack   = 1'b1;
    bus_rdata = 32'h0BAD_F00D;
    tick();
    chk("sh_rd_kept", read_data, 32'h0000_1234);
    $display("store SH addr=0x00000102 done stall=%0b", stall);
    clear_req();
    tick();

    // Timeout: 4 REQ cycles without ack
    start(1'b1, 1'b0, 3'b010, 32'h0000_0200, 32'h0);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req%0d", i), {31'h0, bus_req}, 32'h1);
      tick();
    end
    chk("to_req_drop", {31'h0, bus_req}, 32'h0);
    chk("to_err", {31'h0, bus_error}, 32'h1);
    chk("to_data", read_data, 32'h0);
    chk("to_stall", {31'h0, stall}, 32'h0);
    $display("timeout LW addr=0x00000200 bus_error=%0b", bus_error);
    clear_req();
    tick();
    chk("to_err_pulse", {31'h0, bus_error}, 32'h0);

    // Reset in the 2nd REQ cycle, stale ack afterwards
    start(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
    tick();
    tick();
    chk("rr_req_before", {31'h0, bus_req}, 32'h1);
    reset    = 1'b0;
    mem_read = 1'b0;
    #1;
    chk("rr_req_async", {31'h0, bus_req}, 32'h0);
    chk("rr_stall", {31'h0, stall}, 32'h0);
    tick();
    reset     = 1'b1;
    bus_ack   = 1'b1;
    bus_rdata = 32'h5555_5555;
    tick();
    chk("rr_stale_req", {31'h0, bus_req}, 32'h0);
    chk("rr_stale_err", {31'h0, bus_error}, 32'h0);
    chk("rr_stale_data", read_data, 32'h0);
    $display("reset mid-REQ bus_req=%0b read_data=0x%08h", bus_req, read_data);
    clear_req();
    tick();

    // LW 0x102: misaligned word
    start(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0);
    chk("lw_mis_stall_n", {31'h0, stall}, 32'h1);
    tick();
`ifdef LSU_MISALIGN_TRAP_EN
    chk("lw_mis_req", {31'h0, bus_req}, 32'h0);
    chk("lw_mis_err", {31'h0, bus_error}, 32'h1);
    chk("lw_mis_data", read_data, 32'h0);
    chk("lw_mis_stall", {31'h0, stall}, 32'h0);
    $display("misaligned LW trapped bus_error=%0b", bus_error);
    clear_req();
    tick();
    chk("lw_mis_err_pulse", {31'h0, bus_error}, 32'h0);
`else
    chk("lw_mis_req", {31'h0, bus_req}, 32'h1);
    chk("lw_mis_addr", bus_addr, 32'h0000_0100);
    chk("lw_mis_be", {28'h0, bus_be}, 32'hF);
    bus_ack   = 1'b1;
    bus_rdata = 32'hDEAD_BEEF;
    tick();
    chk("lw_mis_data", read_data, 32'hDEAD_BEEF);
    chk("lw_mis_err", {31'h0, bus_error}, 32'h0);
    $display("misaligned LW issued read_data=0x%08h", read_data);
    clear_req();
    tick();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
